cpu_uart_rx: RTL

//  UART receiver fed by cpu_baudrate. Treats baud_rate_clk as a 16x-oversample

---
 rtl/cpu_uart_rx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_uart_rx.sv
// UART receiver: 16x-oversampled 8N1 deserialiser driven by a baud tick strobe.
// Define CPU_UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module cpu_uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 baud_rate_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;
`ifdef CPU_UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
  logic par_q, par_d;
  logic perr_q, perr_d;
`endif

  logic                 rx_meta_q, rx_s_q;
  logic                 bclk_meta_q, bclk_s_q, bclk_d_q;
  logic                 tick;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 cnt_half, cnt_last;

  assign tick     = bclk_s_q & ~bclk_d_q;
  assign cnt_half = (cnt_q == CW'(OVERSAMPLE / 2 - 1));
  assign cnt_last = (cnt_q == CW'(OVERSAMPLE - 1));

  always_comb begin
    // NOTE: every next-state signal takes a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef CPU_UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_half) begin
            cnt_d   = '0;
            idx_d   = '0;
            // A start bit that is high again at its midpoint was a glitch.
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_last) begin
            cnt_d   = '0;
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            idx_d   = idx_q + IW'(1);
            if (idx_q == IW'(DATA_BITS - 1)) begin
`ifdef CPU_UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
`ifdef CPU_UART_RX_PARITY_EN
        S_PARITY: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_last) begin
            cnt_d   = '0;
            par_d   = rx_s_q;
            state_d = S_STOP;
          end
        end
`endif
        S_STOP: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_last) begin
            cnt_d = '0;
            if (!rx_s_q) begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
`ifdef CPU_UART_RX_PARITY_EN
            else if (^{shift_q, par_q}) begin
              perr_d  = 1'b1;
              state_d = S_IDLE;
            end
`endif
            else begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_BREAK: begin
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      bclk_meta_q <= 1'b0;
      bclk_s_q    <= 1'b0;
      bclk_d_q    <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef CPU_UART_RX_PARITY_EN
      par_q       <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      bclk_meta_q <= baud_rate_clk;
      bclk_s_q    <= bclk_meta_q;
      bclk_d_q    <= bclk_s_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
`ifdef CPU_UART_RX_PARITY_EN
      par_q       <= par_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != S_IDLE);
`ifdef CPU_UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
